// File: rtl/dpram_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dpram_access_ctrl_pkg
//   Shared definitions for the dual-port RAM access controller:
//   default widths, controller state encoding, round-robin pointer values
//   and the same-address hazard predicate.
// ---------------------------------------------------------------------------
package dpram_access_ctrl_pkg;

  localparam int DW_DEF = 8;  // default data width
  localparam int AW_DEF = 8;  // default address width
  localparam int CW_DEF = 8;  // default collision counter width

  // Controller states
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Round-robin pointer: which requester wins the next hazard
  typedef enum logic {
    RR_R0 = 1'b0,
    RR_R1 = 1'b1
  } rr_ptr_e;

  // Two requests to one address conflict unless both are reads.
  function automatic logic is_hazard(input logic req0, input logic req1,
                                     input logic we0,  input logic we1,
                                     input logic addr_eq);
    return req0 & req1 & addr_eq & (we0 | we1);
  endfunction

endpackage

// File: rtl/dpram_access_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin arbiter. Without a hazard every request is
//   granted as-is; on a hazard only the requester named by the pointer is
//   granted and the pointer then moves to the other requester. The pointer
//   never moves on non-hazard cycles.
// Ports
//   clk       in   clock
//   rst       in   asynchronous active-low reset (pointer -> R0)
//   req_i     in   [1:0] requests, bit0 = R0, bit1 = R1
//   hazard_i  in   same-address conflict this cycle
//   gnt_o     out  [1:0] grants (combinational)
// ---------------------------------------------------------------------------
module rr_arb2
  import dpram_access_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       hazard_i,
  output logic [1:0] gnt_o
);

  rr_ptr_e ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= RR_R0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    gnt_o = req_i;
    if (hazard_i) begin
      gnt_o = (ptr_q == RR_R0) ? 2'b01 : 2'b10;
      ptr_d = (ptr_q == RR_R0) ? RR_R1 : RR_R0;
    end
  end

endmodule

// File: rtl/dpram_access_ctrl.sv
// ---------------------------------------------------------------------------
// dpram_access_ctrl
//   Access controller owning both ports of an external true dual-port RAM.
//   R0 is served on port A, R1 on port B, each through a req/gnt handshake.
//   After reset the RAM is optionally zero-filled through port A; afterwards
//   same-address conflicts are resolved round-robin and counted.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   rX_req/we/addr/wdata     requester X request and qualifiers (held to gnt)
//   rX_gnt                   request accepted this cycle (combinational)
//   rX_rvalid/rX_rdata       read return, one cycle after a granted read
//   we_a/add_a/data_a        RAM port A controls
//   we_b/add_b/data_b        RAM port B controls
//   read_a/read_b            RAM read data (synchronous, 1-cycle latency)
//   init_busy                high while the RAM is being cleared
//   coll_cnt                 saturating hazard counter
// ---------------------------------------------------------------------------
module dpram_access_ctrl
  import dpram_access_ctrl_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int CW         = CW_DEF,
  parameter int INIT_CLEAR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          we_a,
  output logic          we_b,
  output logic [AW-1:0] add_a,
  output logic [AW-1:0] add_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  input  logic [DW-1:0] read_a,
  input  logic [DW-1:0] read_b,
  output logic          init_busy,
  output logic [CW-1:0] coll_cnt
);

  localparam state_e        ST_AFTER_RST = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
  localparam logic [AW-1:0] CNT_LAST     = '1;
  localparam logic [CW-1:0] COLL_MAX     = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] coll_q, coll_d;
  logic          r0_rvalid_q, r1_rvalid_q;
  logic [DW-1:0] r0_rdata_q, r1_rdata_q;

  logic          run;
  logic          hazard;
  logic [1:0]    arb_gnt;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_AFTER_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // INIT walks every address once and has no exit other than completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == CNT_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  // Grants are also blocked while reset is held, so a RUN-after-reset
  // configuration never accepts a request during reset.
  assign run    = rst & (state_q == ST_RUN);
  assign hazard = run & is_hazard(r0_req, r1_req, r0_we, r1_we, r0_addr == r1_addr);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({r1_req & run, r0_req & run}),
    .hazard_i (hazard),
    .gnt_o    (arb_gnt)
  );

  assign r0_gnt = arb_gnt[0];
  assign r1_gnt = arb_gnt[1];

  // ---------------- FSM: outputs / RAM port muxes ----------------
  always_comb begin
    we_a      = 1'b0;
    add_a     = '0;
    data_a    = '0;
    we_b      = 1'b0;
    add_b     = '0;
    data_b    = '0;
    init_busy = 1'b0;
    if (state_q == ST_INIT) begin
      init_busy = 1'b1;
      we_a      = 1'b1;
      add_a     = cnt_q;
    end else begin
      if (r0_gnt) begin
        we_a   = r0_we;
        add_a  = r0_addr;
        data_a = r0_wdata;
      end
      if (r1_gnt) begin
        we_b   = r1_we;
        add_b  = r1_addr;
        data_b = r1_wdata;
      end
    end
  end

  // ---------------- Collision counter ----------------
  always_comb begin
    coll_d = coll_q;
    if (hazard && (coll_q != COLL_MAX)) begin
      coll_d = coll_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll_q <= '0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign coll_cnt = coll_q;

  // ---------------- Read return ----------------
  // The RAM registers the read on the grant edge, so its data is present on
  // read_x during the cycle after the grant. rvalid marks that cycle and the
  // data is forwarded directly; it is captured at the end of the valid cycle
  // so rdata keeps the last returned value afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      r0_rvalid_q <= r0_gnt & ~r0_we;
      r1_rvalid_q <= r1_gnt & ~r1_we;
      if (r0_rvalid_q) begin
        r0_rdata_q <= read_a;
      end
      if (r1_rvalid_q) begin
        r1_rdata_q <= read_b;
      end
    end
  end

  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rvalid_q ? read_a : r0_rdata_q;
  assign r1_rdata  = r1_rvalid_q ? read_b : r1_rdata_q;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dpram_access_ctrl
//   Main instance: INIT_CLEAR=1, CW=8, attached to a behavioural dual-port
//   RAM that is filled with random garbage during reset. A second instance
//   (INIT_CLEAR=0, CW=2) exercises counter saturation.
//   Expected values come from a transaction-level reference: a shadow memory,
//   an integer "whose turn" for conflicts and an integer collision count.
// ---------------------------------------------------------------------------
module tb_dpram_access_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic       rst;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0] r0_rdata, r1_rdata;
  logic       we_a, we_b;
  logic [7:0] add_a, add_b, data_a, data_b, read_a, read_b;
  logic       init_busy;
  logic [7:0] coll_cnt;

  dpram_access_ctrl #(.DW(8), .AW(8), .CW(8), .INIT_CLEAR(1)) u_dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .we_a(we_a), .we_b(we_b), .add_a(add_a), .add_b(add_b),
    .data_a(data_a), .data_b(data_b), .read_a(read_a), .read_b(read_b),
    .init_busy(init_busy), .coll_cnt(coll_cnt)
  );

  // Behavioural true dual-port RAM, synchronous read
  logic [7:0] ram [256];
  logic       scramble;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'($urandom);
    end else begin
      if (we_a) ram[add_a] <= data_a;
      if (we_b) ram[add_b] <= data_b;
    end
    read_a <= ram[add_a];
    read_b <= ram[add_b];
  end

  // ---------------- saturation instance ----------------
  logic       s_rst;
  logic       s_r0_req, s_r0_we, s_r1_req, s_r1_we;
  logic [7:0] s_r0_addr, s_r0_wdata, s_r1_addr, s_r1_wdata;
  logic       s_r0_gnt, s_r0_rvalid, s_r1_gnt, s_r1_rvalid;
  logic [7:0] s_r0_rdata, s_r1_rdata;
  logic       s_we_a, s_we_b;
  logic [7:0] s_add_a, s_add_b, s_data_a, s_data_b;
  logic [7:0] s_read_a, s_read_b;
  logic       s_init_busy;
  logic [1:0] s_coll_cnt;

  dpram_access_ctrl #(.DW(8), .AW(8), .CW(2), .INIT_CLEAR(0)) u_sat (
    .clk(clk), .rst(s_rst),
    .r0_req(s_r0_req), .r0_we(s_r0_we), .r0_addr(s_r0_addr), .r0_wdata(s_r0_wdata),
    .r0_gnt(s_r0_gnt), .r0_rvalid(s_r0_rvalid), .r0_rdata(s_r0_rdata),
    .r1_req(s_r1_req), .r1_we(s_r1_we), .r1_addr(s_r1_addr), .r1_wdata(s_r1_wdata),
    .r1_gnt(s_r1_gnt), .r1_rvalid(s_r1_rvalid), .r1_rdata(s_r1_rdata),
    .we_a(s_we_a), .we_b(s_we_b), .add_a(s_add_a), .add_b(s_add_b),
    .data_a(s_data_a), .data_b(s_data_b), .read_a(s_read_a), .read_b(s_read_b),
    .init_busy(s_init_busy), .coll_cnt(s_coll_cnt)
  );

  // ---------------- reference model state ----------------
  logic [7:0] ref_mem [256];
  int         turn_m;        // 0: R0 wins the next conflict, 1: R1
  int         coll_m;
  logic [7:0] last0, last1;  // last read value returned to each requester
  logic [7:0] obs0, obs1;    // DUT read data seen on the latest valid return
  int         err_cnt = 0;
  int         chk_cnt = 0;
  int         txn_no  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    turn_m = 0;
    coll_m = 0;
    last0  = 8'h00;
    last1  = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  // One transaction: each requester (if present) holds its request until the
  // reference says it is granted. Called and returns at a falling edge.
  task automatic run_txn(input logic q0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic q1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    logic       p0, p1, eg0, eg1, ev0, ev1;
    logic [7:0] er0, er1;
    int         n;
    p0 = q0; p1 = q1; n = 0; er0 = 8'h00; er1 = 8'h00;
    r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_we = w1; r1_addr = a1; r1_wdata = d1;
    while ((p0 || p1) && n < 4) begin
      r0_req = p0;
      r1_req = p1;
      #1;
      if (p0 && p1 && (a0 == a1) && (w0 || w1)) begin
        eg0 = (turn_m == 0);
        eg1 = (turn_m == 1);
        turn_m = 1 - turn_m;
        if (coll_m < 255) coll_m++;
      end else begin
        eg0 = p0;
        eg1 = p1;
      end
      check_val("gnt0", r0_gnt, eg0);
      check_val("gnt1", r1_gnt, eg1);
      ev0 = eg0 && !w0;
      ev1 = eg1 && !w1;
      if (ev0) er0 = ref_mem[a0];
      if (ev1) er1 = ref_mem[a1];
      if (eg0 && w0) ref_mem[a0] = d0;
      if (eg1 && w1) ref_mem[a1] = d1;
      @(posedge clk);
      #1;
      if (ev0) last0 = er0;
      if (ev1) last1 = er1;
      check_val("rvalid0", r0_rvalid, ev0);
      check_val("rvalid1", r1_rvalid, ev1);
      check_val("rdata0", r0_rdata, last0);
      check_val("rdata1", r1_rdata, last1);
      check_val("coll_cnt", coll_cnt, coll_m);
      if (ev0) obs0 = r0_rdata;
      if (ev1) obs1 = r1_rdata;
      if (eg0) p0 = 1'b0;
      if (eg1) p1 = 1'b0;
      n++;
      @(negedge clk);
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    txn_no++;
    $display("txn %0d: r0 %s %s@%02h:%02h | r1 %s %s@%02h:%02h | coll=%0d", txn_no,
             q0 ? "req" : "---", w0 ? "W" : "R", a0, d0,
             q1 ? "req" : "---", w1 ? "W" : "R", a1, d1, coll_cnt);
  endtask

  initial begin
    int n;
    logic q0, q1;

    rst = 1'b0; s_rst = 1'b0; scramble = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h3C; r0_wdata = 8'h00;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 8'h3C; r1_wdata = 8'h00;
    s_r0_req = 1'b1; s_r0_we = 1'b1; s_r0_addr = 8'h07; s_r0_wdata = 8'hA5;
    s_r1_req = 1'b1; s_r1_we = 1'b1; s_r1_addr = 8'h07; s_r1_wdata = 8'h5A;
    s_read_a = 8'h00; s_read_b = 8'h00;
    model_reset();
    obs0 = 8'h00; obs1 = 8'h00;

    // ---- outputs while reset is held ----
    repeat (3) @(negedge clk);
    scramble = 1'b0;
    #1;
    check_val("rst_init_busy", init_busy, 1);
    check_val("rst_we_a", we_a, 1);
    check_val("rst_add_a", add_a, 0);
    check_val("rst_data_a", data_a, 0);
    check_val("rst_gnt0", r0_gnt, 0);
    check_val("rst_gnt1", r1_gnt, 0);
    check_val("rst_coll", coll_cnt, 0);
    check_val("rst_rvalid0", r0_rvalid, 0);
    check_val("s_rst_busy", s_init_busy, 0);
    check_val("s_rst_gnt", {s_r1_gnt, s_r0_gnt}, 0);
    check_val("s_rst_port", {s_we_a, s_we_b, s_add_a, s_add_b, s_data_a, s_data_b}, 0);

    // ---- T1: INIT sweep with both reads of 0x3C held pending ----
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      check_val("init_busy", init_busy, 1);
      check_val("init_we_a", we_a, 1);
      check_val("init_add_a", add_a, i);
      check_val("init_data_a", data_a, 0);
      check_val("init_gnt", {r1_gnt, r0_gnt}, 0);
      check_val("init_we_b", we_b, 0);
      @(negedge clk);
    end
    #1;
    check_val("init_done", init_busy, 0);
    @(negedge clk);
    run_txn(1, 0, 8'h3C, 8'h00, 1, 0, 8'h3C, 8'h00);
    check_val("t1_rd0", obs0, 8'h00);
    check_val("t1_rd1", obs1, 8'h00);

    // ---- T2: parallel writes, then read back ----
    run_txn(1, 1, 8'h05, 8'h0A, 1, 1, 8'h10, 8'h30);
    run_txn(1, 0, 8'h05, 8'h00, 1, 0, 8'h10, 8'h00);
    check_val("t2_rd0", obs0, 8'h0A);
    check_val("t2_rd1", obs1, 8'h30);

    // ---- T3: write-write conflict, R0 first ----
    run_txn(1, 1, 8'h07, 8'h11, 1, 1, 8'h07, 8'h22);
    check_val("t3_coll", coll_cnt, 1);
    run_txn(1, 0, 8'h07, 8'h00, 0, 0, 8'h00, 8'h00);
    check_val("t3_rd", obs0, 8'h22);

    // ---- T4: repeat, R1 first now ----
    run_txn(1, 1, 8'h07, 8'h11, 1, 1, 8'h07, 8'h22);
    check_val("t4_coll", coll_cnt, 2);
    run_txn(0, 0, 8'h00, 8'h00, 1, 0, 8'h07, 8'h00);
    check_val("t4_rd", obs1, 8'h11);

    // ---- T5: both read the same address ----
    run_txn(1, 0, 8'h05, 8'h00, 1, 0, 8'h05, 8'h00);
    check_val("t5_coll", coll_cnt, 2);
    check_val("t5_rd0", obs0, 8'h0A);
    check_val("t5_rd1", obs1, 8'h0A);

    // ---- random traffic over a small address window ----
    for (int k = 0; k < 300; k++) begin
      q0 = 1'($urandom_range(0, 1));
      q1 = 1'($urandom_range(0, 1));
      if (!q0 && !q1) q0 = 1'b1;
      run_txn(q0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom),
              q1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
    end

    // ---- T6: reset while an R0 read is returning ----
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'h05;
    #1;
    check_val("t6_gnt0", r0_gnt, 1);
    @(posedge clk);
    #1;
    r0_req = 1'b0;
    check_val("t6_rvalid_pre", r0_rvalid, 1);
    check_val("t6_rdata_pre", r0_rdata, ref_mem[8'h05]);
    rst = 1'b0;
    #1;
    check_val("t6_rvalid", r0_rvalid, 0);
    check_val("t6_rdata", r0_rdata, 0);
    check_val("t6_coll", coll_cnt, 0);
    check_val("t6_busy", init_busy, 1);
    scramble = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    scramble = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n = 0;
    while (init_busy && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val("t6_init_len", n, 256);
    @(negedge clk);
    run_txn(1, 0, 8'h05, 8'h00, 1, 0, 8'h07, 8'h00);
    check_val("t6_clr0", obs0, 8'h00);
    check_val("t6_clr1", obs1, 8'h00);

    // ---- T7: CW=2 counter saturates at 3 ----
    s_rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check_val("s_gnt0", s_r0_gnt, (k % 2) == 1);
      check_val("s_gnt1", s_r1_gnt, (k % 2) == 0);
      @(posedge clk);
      #1;
      check_val("s_coll", s_coll_cnt, (k < 3) ? k : 3);
      check_val("s_rvalid", {s_r1_rvalid, s_r0_rvalid}, 0);
      check_val("s_rdata", {s_r1_rdata, s_r0_rdata}, 0);
      check_val("s_busy", s_init_busy, 0);
      $display("txn sat %0d: coll=%0d", k, s_coll_cnt);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
